// File: rtl/avmm_block_reader_pkg.sv
// Shared constants and types for the Avalon-MM block reader.
// AVMM_BLOCK_READER_TLAST_EN widens each buffered word by a last flag.
package avmm_block_reader_pkg;

    localparam int ADDR_W         = 13;
    localparam int DATA_W         = 16;
    localparam int CNT_W          = 14;
    localparam int FIFO_DEPTH_DEF = 4;

`ifdef AVMM_BLOCK_READER_TLAST_EN
    localparam int FIFO_W = DATA_W + 1;
`else
    localparam int FIFO_W = DATA_W;
`endif

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } state_e;

endpackage

// File: rtl/avmm_block_reader_if.sv
// Memory-side Avalon-MM signals plus the outgoing word stream.
// m_tlast exists only with AVMM_BLOCK_READER_TLAST_EN.
interface avmm_block_reader_if;
    import avmm_block_reader_pkg::*;

    addr_t      avm_address;
    logic       avm_chipselect;
    logic       avm_write;
    logic [1:0] avm_byteenable;
    data_t      avm_writedata;
    logic       avm_clken;
    data_t      avm_readdata;

    data_t      m_tdata;
    logic       m_tvalid;
    logic       m_tready;
`ifdef AVMM_BLOCK_READER_TLAST_EN
    logic       m_tlast;

    modport master (
        output avm_address, avm_chipselect, avm_write,
        output avm_byteenable, avm_writedata, avm_clken,
        input  avm_readdata,
        output m_tdata, m_tvalid, m_tlast,
        input  m_tready
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write,
        input  avm_byteenable, avm_writedata, avm_clken,
        output avm_readdata,
        input  m_tdata, m_tvalid, m_tlast,
        output m_tready
    );
`else
    modport master (
        output avm_address, avm_chipselect, avm_write,
        output avm_byteenable, avm_writedata, avm_clken,
        input  avm_readdata,
        output m_tdata, m_tvalid,
        input  m_tready
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write,
        input  avm_byteenable, avm_writedata, avm_clken,
        output avm_readdata,
        input  m_tdata, m_tvalid,
        output m_tready
    );
`endif

endinterface

// File: rtl/avmm_rd_fifo.sv
// Small synchronous FIFO buffering read data ahead of the stream port.
// DEPTH must be a power of two so the pointers wrap naturally.
module avmm_rd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) wr_d = wr_q + 1'b1;
        if (pop_i)  rd_d = rd_q + 1'b1;
        if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
        else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/avmm_block_reader.sv
// Reads a block of words from on-chip RAM and streams them out in order.
// AVMM_BLOCK_READER_TLAST_EN adds m_tlast on the final word.
module avmm_block_reader
    import avmm_block_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  start,
    input  addr_t start_addr,
    input  cnt_t  word_count,
    output logic  busy,
    output logic  done,
    avmm_block_reader_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    addr_t             addr_q, addr_d;
    cnt_t              rem_q, rem_d;
    logic              inflight_q;
    logic              issue;
    logic              credit;
    logic              pop;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty;
    logic              fifo_full;
    logic [FIFO_W-1:0] fifo_wdata;
    logic [FIFO_W-1:0] fifo_head;
`ifdef AVMM_BLOCK_READER_TLAST_EN
    logic              last_q;
`endif

    // Buffered plus in-flight words never exceed the FIFO depth.
    assign credit = (int'(fifo_cnt) + int'(inflight_q)) < FIFO_DEPTH;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        issue   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    rem_d   = word_count;
                    state_d = (word_count != '0) ? READ : FINISH;
                end
            end
            READ: begin
                if (rem_q != '0 && credit) begin
                    issue  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight_q && fifo_empty) state_d = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
`ifdef AVMM_BLOCK_READER_TLAST_EN
            last_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= issue;
`ifdef AVMM_BLOCK_READER_TLAST_EN
            last_q     <= issue && (rem_q == CNT_W'(1));
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign pop  = !fifo_empty && bus.m_tready;

`ifdef AVMM_BLOCK_READER_TLAST_EN
    assign fifo_wdata  = {last_q, bus.avm_readdata};
    assign bus.m_tlast = !fifo_empty && fifo_head[DATA_W];
`else
    assign fifo_wdata  = bus.avm_readdata;
`endif

    avmm_rd_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.avm_address    = addr_q;
    assign bus.avm_chipselect = issue;
    assign bus.avm_write      = 1'b0;
    assign bus.avm_byteenable = 2'b11;
    assign bus.avm_writedata  = '0;
    assign bus.avm_clken      = 1'b1;
    assign bus.m_tvalid       = !fifo_empty;
    assign bus.m_tdata        = fifo_head[DATA_W-1:0];

    a_no_ovf: assert property (@(posedge clk) disable iff (!reset_n)
        !(inflight_q && fifo_full));

endmodule

// File: doc/avmm_block_reader.md
Name: avmm_block_reader

Overview:
- Avalon-MM initiator that reads a programmed range of 16-bit words from the on-chip single-port RAM (13-bit word address, 1-cycle read latency) and presents them as a valid/ready stream.
- Sits between the on-chip memory slave and the stream/FIFO datapath. It is the reading end for data that other masters write into the memory.
- Software or an upstream FSM supplies start address and word count, pulses start, and waits for done.

Parameters:
- ADDR_W, 13, word address width (8192-word memory).
- DATA_W, 16, data width.
- CNT_W, 14, word-count width; holds 0..8192.
- FIFO_DEPTH, 4, output buffer entries; power of two, minimum 3.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_W  first word address.
- word_count  in  CNT_W  number of words to read.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- avm_address  out  ADDR_W  memory address.
- avm_chipselect  out  1  read strobe (memory clocken-qualified).
- avm_write  out  1  tied 0.
- avm_byteenable  out  2  tied 2'b11.
- avm_writedata  out  DATA_W  tied 0.
- avm_clken  out  1  tied 1.
- avm_readdata  in  DATA_W  memory output, valid the cycle after the address is sampled.
- m_tdata  out  DATA_W  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  present only with the macro.

Behaviour:
- Reset (reset_n=0 at a clk edge), regardless of state:
  - State goes to IDLE; FIFO, in-flight flag and counters are cleared.
  - busy=0, done=0, m_tvalid=0, avm_chipselect=0, avm_address=0, m_tlast=0.
  - A reset mid-transfer discards all in-flight and buffered data.
- FSM states: IDLE, READ, DRAIN, FINISH.
  - IDLE: start=1 latches addr_q=start_addr and rem_q=word_count. Go to READ if word_count≠0, else to FINISH.
  - READ: issue condition is rem_q≠0 and (fifo_count + inflight) < FIFO_DEPTH.
    - On issue: avm_chipselect=1, avm_address=addr_q, addr_q++ (wraps 8191→0, mod 2^ADDR_W), rem_q--, inflight=1 for the next cycle.
    - The issue decision depends on registered state only; there is no combinational path from m_tready to avm_*.
    - Go to DRAIN when rem_q reaches 0 on issue.
  - DRAIN: no issues. Go to FINISH when inflight=0 and fifo_count=0.
  - FINISH: done=1 for exactly one cycle, busy=0 next, return to IDLE.
- Read capture: when inflight=1, avm_readdata is pushed into the FIFO at the end of that cycle.
  - A push can never overflow the FIFO; the credit rule guarantees this. An overflow is an assertion failure.
- Stream rules:
  - m_tvalid = FIFO not empty; m_tdata = FIFO head.
  - A pop occurs when m_tvalid & m_tready.
  - m_tdata and m_tvalid stay stable while m_tvalid=1 and m_tready=0.
  - Push and pop in the same cycle leave fifo_count unchanged.
- Latency: start accepted at cycle 0 → first chipselect in cycle 1 → m_tvalid in cycle 3.
- Throughput: with m_tready held at 1, one word per cycle sustained. Done asserts 2 cycles after the last pop.
- start while busy: ignored, with no effect on the running transfer.
- word_count=8192: reads the entire memory. If start_addr≠0 the address wraps.

Optional Feature:
- Macro: AVMM_BLOCK_READER_TLAST_EN.
- Defined:
  - m_tlast port exists.
  - FIFO stores DATA_W+1 bits; the extra bit is set on the entry from the issue where rem_q went 1→0.
  - m_tlast=1 alongside that word.
- Undefined:
  - No m_tlast port and no extra storage bit; all other behaviour is identical.

Decomposition:
- Package avmm_block_reader_pkg:
  - ADDR_W, DATA_W, CNT_W constants.
  - State enum typedef {IDLE, READ, DRAIN, FINISH}.
  - Typedefs addr_t and data_t.
- Sub-module avmm_rd_fifo: synchronous FIFO, parameterised width/depth, with push, pop, count, empty, full, head data, and synchronous active-low reset.

Test Plan:
- start_addr=0x0010, word_count=4, memory[0x10..0x13]=A0,A1,A2,A3, m_tready=1 → m_tvalid in cycles 3–6 with data A0..A3; done pulse in cycle 8; exactly 4 chipselects on addresses 0x10..0x13.
- start_addr=0x1FFE, word_count=4 → addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001; data order preserved.
- word_count=8, m_tready toggling 1,0,0,1 pattern → all 8 words delivered in order; no data change while stalled; fifo_count never exceeds 4.
- word_count=0 → done pulse in cycle 1; no chipselect and no m_tvalid ever.
- reset_n=0 for 1 cycle after 3 of 10 words delivered → m_tvalid=0, busy=0, no done. A new start then reads from the new start_addr cleanly.
- With AVMM_BLOCK_READER_TLAST_EN, word_count=3 → m_tlast=1 only on the third word; word_count=1 → m_tlast=1 on the only word.
